// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;
  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned OFFSET_W  = 5;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned IDX_W     = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;
endpackage

// File: rtl/dmem_responder_if.sv
// Cache-controller <-> memory line request/acknowledge bus.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic                 mem_enable_i;
  logic                 mem_write_i;
  logic [ADDR_W-1:0]    mem_addr_i;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic                 mem_err_o;
  logic                 busy_o;

  modport master (
    output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
    input  mem_ack_o, mem_data_o, mem_err_o, busy_o
  );

  modport slave (
    input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
    output mem_ack_o, mem_data_o, mem_err_o, busy_o
  );
endinterface

// File: rtl/dmem_responder_line_array.sv
// Single-port line storage with a registered, clearable read port.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 512,
  parameter int unsigned AW        = 9
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic                 clr,
  input  logic [AW-1:0]        idx,
  input  logic [LINE_BITS-1:0] wdata,
  output logic [LINE_BITS-1:0] rdata
);
  // Contents are never reset; the bench preloads them hierarchically.
  logic [LINE_BITS-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: accepts one line request, waits LATENCY cycles, acks once.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 512,
  parameter int unsigned LATENCY   = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dmem_responder_if.slave mem
);
  localparam int unsigned     AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic                 wr_q;
  logic [IDX_W-1:0]     idx_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic                 ack_q, err_q, busy_q;

  logic                 in_idle;
  logic                 cur_write;
  logic [IDX_W-1:0]     cur_idx;
  logic [LINE_BITS-1:0] cur_wdata;
  logic                 cur_in_range;
  logic                 enter_ack;
  logic                 arr_we, arr_re, arr_clr;
  logic                 unused_offset;

  assign unused_offset = ^mem.mem_addr_i[OFFSET_W-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (mem.mem_enable_i) state_d = (LATENCY == 1) ? ACK : WAIT;
      WAIT:    if (cnt_q == '0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is the acceptance edge, so the live
  // inputs stand in for the not-yet-loaded request latches.
  always_comb begin
    in_idle      = (state_q == IDLE);
    cur_write    = in_idle ? mem.mem_write_i : wr_q;
    cur_idx      = in_idle ? mem.mem_addr_i[ADDR_W-1:OFFSET_W] : idx_q;
    cur_wdata    = in_idle ? mem.mem_data_i : wdata_q;
    cur_in_range = (cur_idx < DEPTH_IDX);
    enter_ack    = rst_i && (state_d == ACK);
    arr_we       = enter_ack && cur_write && cur_in_range;
    arr_re       = enter_ack && !cur_write && cur_in_range;
    arr_clr      = !rst_i || (enter_ack && !cur_write && !cur_in_range);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ACK);
      err_q   <= (state_d == ACK) && !cur_in_range;
      busy_q  <= (state_d != IDLE);
      if (in_idle && mem.mem_enable_i) begin
        wr_q    <= mem.mem_write_i;
        idx_q   <= mem.mem_addr_i[ADDR_W-1:OFFSET_W];
        wdata_q <= mem.mem_data_i;
        cnt_q   <= CNT_LOAD;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  dmem_line_array #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) u_array (
    .clk   (clk_i),
    .we    (arr_we),
    .re    (arr_re),
    .clr   (arr_clr),
    .idx   (cur_idx[AW-1:0]),
    .wdata (cur_wdata),
    .rdata (mem.mem_data_o)
  );

  assign mem.mem_ack_o = ack_q;
  assign mem.mem_err_o = err_q;
  assign mem.busy_o    = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned LAT   = 10;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  dmem_responder_if mem_bus();

  dmem_responder #(
    .MEM_DEPTH (DEPTH),
    .LATENCY   (LAT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .mem   (mem_bus)
  );

  typedef struct {
    logic [255:0] data;
    logic         err;
  } exp_t;

  exp_t         sb[$];
  logic [255:0] model [DEPTH];
  logic [255:0] last_rd;
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int unsigned idx, input logic [255:0] v);
    dut.u_array.mem[idx] = v;
    model[idx] = v;
  endtask

  task automatic request(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [255:0] d, input bit churn);
    exp_t        e;
    exp_t        got;
    int unsigned idx;
    int          cyc;
    bit          seen;
    idx   = int'(addr[31:5]);
    e.err = (idx >= DEPTH);
    if (wr) begin
      if (!e.err) model[idx] = d;
      e.data = last_rd;
    end else begin
      e.data  = e.err ? '0 : model[idx];
      last_rd = e.data;
    end
    sb.push_back(e);

    @(negedge clk);
    mem_bus.mem_enable_i = 1'b1;
    mem_bus.mem_write_i  = wr;
    mem_bus.mem_addr_i   = addr;
    mem_bus.mem_data_i   = d;
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      if (cyc == 0) chk({tag, "_busy"}, 256'(mem_bus.busy_o), 256'(1));
      if (churn && cyc == 3) begin
        mem_bus.mem_addr_i  = addr ^ 32'h0000_0120;
        mem_bus.mem_data_i  = ~d;
        mem_bus.mem_write_i = ~wr;
      end
      if (mem_bus.mem_ack_o === 1'b1) begin
        seen = 1'b1;
        mem_bus.mem_enable_i = 1'b0;
      end else begin
        @(posedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      chk({tag, "_ack_timeout"}, 256'(mem_bus.mem_ack_o), 256'(1));
      mem_bus.mem_enable_i = 1'b0;
    end
    got.data = mem_bus.mem_data_o;
    got.err  = mem_bus.mem_err_o;
    e = sb.pop_front();
    chk({tag, "_latency"}, 256'(cyc), 256'(LAT));
    chk({tag, "_data"}, got.data, e.data);
    chk({tag, "_err"}, 256'(got.err), 256'(e.err));
    @(negedge clk);
    chk({tag, "_ack_fall"}, {254'd0, mem_bus.mem_ack_o, mem_bus.busy_o}, 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] l0, l3, l5, wa, wb;
    l0 = {8{32'hA5A5_0000}};
    l3 = {8{32'hDEAD_BEEF}};
    l5 = {8{32'h5555_AAAA}};
    wa = {8{32'h1234_5678}};
    wb = {4{64'hCAFE_F00D_0BAD_BEEF}};

    rst_i = 1'b0;
    mem_bus.mem_enable_i = 1'b0;
    mem_bus.mem_write_i  = 1'b0;
    mem_bus.mem_addr_i   = '0;
    mem_bus.mem_data_i   = '0;
    last_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle", {mem_bus.mem_data_o[253:0], mem_bus.mem_ack_o,
          mem_bus.mem_err_o | mem_bus.busy_o | (|mem_bus.mem_data_o[255:254])}, '0);
    end

    preload(0, l0);
    preload(3, l3);
    preload(5, l5);

    request("read3", 1'b0, 32'h0000_0060, '0, 1'b0);
    request("write3", 1'b1, 32'h0000_007F, wa, 1'b0);
    request("readback3", 1'b0, 32'h0000_0060, '0, 1'b0);

    request("churn_write4", 1'b1, 32'h0000_0080, wb, 1'b1);
    request("read4", 1'b0, 32'h0000_0080, '0, 1'b0);
    request("read3_after_churn", 1'b0, 32'h0000_0060, '0, 1'b0);

    request("oor_read", 1'b0, DEPTH * 32, '0, 1'b0);
    request("oor_write", 1'b1, DEPTH * 32, ~l0, 1'b0);
    request("read0_after_oor", 1'b0, 32'h0000_0000, '0, 1'b0);

    // Write to line 5 abandoned by reset while waiting.
    @(negedge clk);
    mem_bus.mem_enable_i = 1'b1;
    mem_bus.mem_write_i  = 1'b1;
    mem_bus.mem_addr_i   = 32'h0000_00A0;
    mem_bus.mem_data_i   = ~l5;
    @(posedge clk);
    repeat (4) @(negedge clk);
    rst_i = 1'b0;
    mem_bus.mem_enable_i = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {mem_bus.mem_data_o[253:0], mem_bus.mem_ack_o,
        mem_bus.mem_err_o | mem_bus.busy_o | (|mem_bus.mem_data_o[255:254])}, '0);
    rst_i   = 1'b1;
    last_rd = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("midreset_no_ack", 256'(mem_bus.mem_ack_o), 256'(0));
    end
    request("read5_after_reset", 1'b0, 32'h0000_00A0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
